// File: rtl/branch_comp.sv
// Execute-stage branch condition evaluator: decides taken/not-taken for RV32I
// conditional branches and forces taken for jumps, registered for PC select.
module branch_comp #(
  parameter int XLEN  = 32,
  parameter int OPLEN = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  rs1data_de,
  input  logic [XLEN-1:0]  rs2data_de,
  input  logic [OPLEN-1:0] decoded_op_de,
  output logic             jamp_state_pre
);

  localparam logic [3:0] CLS_BRANCH = 4'b0011;
  localparam logic [3:0] CLS_JUMP   = 4'b0100;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } funct3_e;

  logic [3:0] op_class;
  logic [2:0] funct3;
  logic       op_rsvd_unused;

  assign op_class       = decoded_op_de[7:4];
  assign funct3         = decoded_op_de[2:0];
  assign op_rsvd_unused = decoded_op_de[3];

  logic cmp_eq;
  logic cmp_ltu;
  logic cmp_lt;
  logic msb_diff;

  // Signed less-than reuses the unsigned comparator: differing sign bits
  // decide outright, equal sign bits leave the unsigned order intact.
  always_comb begin
    cmp_eq   = (rs1data_de == rs2data_de);
    cmp_ltu  = (rs1data_de <  rs2data_de);
    msb_diff = rs1data_de[XLEN-1] ^ rs2data_de[XLEN-1];
    cmp_lt   = msb_diff ? rs1data_de[XLEN-1] : cmp_ltu;
  end

  logic jamp_state_d;
  logic jamp_state_q;

  // Default 0 keeps the result clean when operands are X on non-branch ops.
  always_comb begin
    jamp_state_d = 1'b0;
    if (op_class == CLS_JUMP) begin
      jamp_state_d = 1'b1;
    end else if (op_class == CLS_BRANCH) begin
      case (funct3)
        F3_BEQ:  jamp_state_d = cmp_eq;
        F3_BNE:  jamp_state_d = ~cmp_eq;
        F3_BLT:  jamp_state_d = cmp_lt;
        F3_BGE:  jamp_state_d = ~cmp_lt;
        F3_BLTU: jamp_state_d = cmp_ltu;
        F3_BGEU: jamp_state_d = ~cmp_ltu;
        default: jamp_state_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) jamp_state_q <= 1'b0;
    else     jamp_state_q <= jamp_state_d;
  end

  assign jamp_state_pre = jamp_state_q;

endmodule

// File: tb/tb_branch_comp.sv
// Scoreboard bench for branch_comp: expected taken flags are queued as each
// vector is driven and retired one edge later against jamp_state_pre.
module tb_branch_comp;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rs1data_de;
  logic [31:0] rs2data_de;
  logic [7:0]  decoded_op_de;
  logic        jamp_state_pre;

  int n_cmp = 0;
  int n_bad = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  branch_comp #(.XLEN(32), .OPLEN(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .rs1data_de     (rs1data_de),
    .rs2data_de     (rs2data_de),
    .decoded_op_de  (decoded_op_de),
    .jamp_state_pre (jamp_state_pre)
  );

  task automatic chk(input string tag, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%b exp=%b", tag, got, exp);
    end
  endtask

  function automatic logic model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [7:0] op);
    if (op[7:4] == 4'h4) return 1'b1;
    if (op[7:4] != 4'h3) return 1'b0;
    case (op[2:0])
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) <  $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a <  b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Drive on the falling edge, retire the queued expectation just after the rising edge.
  task automatic apply(input string tag, input logic r, input logic [31:0] a,
                       input logic [31:0] b, input logic [7:0] op);
    @(negedge clk);
    rst = r; rs1data_de = a; rs2data_de = b; decoded_op_de = op;
    exp_q.push_back(r ? 1'b0 : model(a, b, op));
    @(posedge clk);
    #1;
    chk(tag, jamp_state_pre, exp_q.pop_front());
  endtask

  logic [7:0] idle_ops[10] = '{8'h00, 8'h08, 8'h01, 8'h09, 8'h04,
                                8'h0C, 8'h06, 8'h0E, 8'h07, 8'h0F};
  logic [7:0] rnd_ops[12]  = '{8'h30, 8'h31, 8'h34, 8'h35, 8'h36, 8'h37,
                                8'h3C, 8'h3F, 8'h40, 8'h32, 8'h50, 8'h48};

  initial begin
    rst = 1'b1; rs1data_de = '0; rs2data_de = '0; decoded_op_de = '0;
    apply("reset0", 1'b1, 32'h0, 32'h0, 8'h40);
    apply("reset1", 1'b1, 32'h0, 32'h0, 8'h40);
    chk("reset_state", jamp_state_pre, 1'b0);

    foreach (idle_ops[i]) apply($sformatf("idle_%h", idle_ops[i]), 1'b0, 32'h0, 32'h0, idle_ops[i]);

    apply("beq_eq",     1'b0, 32'h5, 32'h5, 8'h30);
    apply("bne_eq",     1'b0, 32'h5, 32'h5, 8'h31);
    apply("beq_ne",     1'b0, 32'h5, 32'h6, 8'h30);
    apply("bne_ne",     1'b0, 32'h5, 32'h6, 8'h31);
    apply("beq_eq_b3",  1'b0, 32'h5, 32'h5, 8'h38);
    apply("bne_eq_b3",  1'b0, 32'h5, 32'h5, 8'h39);
    apply("beq_ne_b3",  1'b0, 32'h5, 32'h6, 8'h38);
    apply("bne_ne_b3",  1'b0, 32'h5, 32'h6, 8'h39);

    apply("blt_sgn",    1'b0, 32'h8000_0015, 32'h3, 8'h34);
    apply("bge_sgn",    1'b0, 32'h8000_0015, 32'h3, 8'h35);
    apply("bltu_sgn",   1'b0, 32'h8000_0015, 32'h3, 8'h36);
    apply("bgeu_sgn",   1'b0, 32'h8000_0015, 32'h3, 8'h37);

    apply("bge_ones",   1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h35);
    apply("bgeu_ones",  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h37);
    apply("blt_ones",   1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h34);
    apply("bltu_ones",  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h36);
    apply("blt_maxmin", 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 8'h34);
    apply("bltu_maxmin",1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 8'h36);

    apply("jump",       1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 8'h40);
    apply("undef_32",   1'b0, 32'h5, 32'h5, 8'h32);
    apply("undef_33",   1'b0, 32'h5, 32'h6, 8'h33);
    apply("class_50",   1'b0, 32'h5, 32'h5, 8'h50);

    // Latency: old result must still be visible before the next rising edge.
    apply("lat_beq",    1'b0, 32'h9, 32'h9, 8'h30);
    @(negedge clk);
    decoded_op_de = 8'h31;
    #1;
    chk("lat_hold", jamp_state_pre, 1'b1);
    apply("lat_bne",    1'b0, 32'h9, 32'h9, 8'h31);

    apply("pre_rst",    1'b0, 32'h9, 32'h9, 8'h30);
    apply("rst_prio",   1'b1, 32'h9, 32'h9, 8'h30);
    apply("post_rst",   1'b0, 32'h9, 32'h9, 8'h30);

    // Operands X on a non-branch class must not leak into the result.
    apply("x_operands", 1'b0, 32'hx, 32'hx, 8'h00);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = (i % 4 == 0) ? a : $urandom;
      if (i % 5 == 0) b[31] = a[31];
      apply($sformatf("rnd%0d", i), 1'b0, a, b, rnd_ops[$urandom_range(0, 11)]);
    end

    chk("queue_empty", exp_q.size() == 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
